gcd_feeder: RTL and testbench

//  Upstream sequencer for the gcd core. Accepts operand pairs over a valid/ready

---
 rtl/gcd_feeder.sv | 163 ++++++++++++++++
 tb/tb_gcd_feeder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_feeder.sv
// Operand FIFO and sequencer in front of the gcd core. Zero operands skip the core, and a watchdog aborts a core that never finishes.
// States: IDLE pop head | ISSUE start pulse | ARM skip stale done | WAIT await done/watchdog | OUT present result
module gcd_feeder #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_err,
  output logic         start,
  output logic [W-1:0] a_in,
  output logic [W-1:0] b_in,
  input  logic         done,
  input  logic [W-1:0] result,
  output logic         busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_OUT} state_t;

  logic [W-1:0]   mem_a_q [DEPTH];
  logic [W-1:0]   mem_b_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           out_valid_q, out_valid_d;
  logic           out_err_q, out_err_d;
  logic [W-1:0]   out_result_q, out_result_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           push, pop;
  logic [W-1:0]   head_a, head_b;

  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign head_a     = mem_a_q[rd_ptr_q];
  assign head_b     = mem_b_q[rd_ptr_q];
  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_result = out_result_q;
  assign start      = start_q;
  assign a_in       = a_q;
  assign b_in       = b_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    a_d          = a_q;
    b_d          = b_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_result_d = out_result_q;
    wd_d         = wd_q;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head_a == '0 || head_b == '0) begin
            out_result_d = head_a | head_b;
            out_err_d    = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = S_OUT;
          end else begin
            a_d     = head_a;
            b_d     = head_b;
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start_d = 1'b0;
        state_d = S_ARM;
      end
      // done may still be high from the previous operation here
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (done) begin
          out_result_d = result;
          out_err_d    = 1'b0;
          out_valid_d  = 1'b1;
          wd_d         = '0;
          state_d      = S_OUT;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          out_result_d = '0;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
          wd_d         = '0;
          state_d      = S_OUT;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      wd_q         <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      start_q      <= start_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_result_q <= out_result_d;
      wd_q         <= wd_d;
    end
  end

endmodule

// File: tb/tb_gcd_feeder.sv
// Bench for gcd_feeder: behavioural gcd core model plus Euclid reference, one task per scenario.
module tb_gcd_feeder;
  localparam int W       = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_err;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         done;
  logic [W-1:0] result;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // gcd core model
  logic         core_done, core_run;
  logic [W-1:0] core_res, core_a, core_b;
  int           core_cnt;
  int           core_lat = 3;
  bit           core_hang = 1'b0;
  bit           stale_en = 1'b0;
  logic [W-1:0] stale_val = 32'hDEAD;
  int           start_cnt = 0;

  always #5 clk = ~clk;

  gcd_feeder #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .start(start), .a_in(a_in),
    .b_in(b_in), .done(done), .result(result), .busy(busy)
  );

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  assign done   = stale_en ? 1'b1 : core_done;
  assign result = stale_en ? stale_val : core_res;

  always @(posedge clk) begin
    if (start) start_cnt <= start_cnt + 1;
    if (!reset_n) begin
      core_done <= 1'b0;
      core_run  <= 1'b0;
      core_res  <= '0;
      core_cnt  <= 0;
      core_a    <= '0;
      core_b    <= '0;
    end else if (start) begin
      core_done <= 1'b0;
      core_run  <= 1'b1;
      core_cnt  <= core_lat;
      core_a    <= a_in;
      core_b    <= b_in;
    end else if (core_run && !core_hang) begin
      if (core_cnt <= 1) begin
        core_done <= 1'b1;
        core_res  <= ref_gcd(core_a, core_b);
        core_run  <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pop_result(input int budget, output bit seen, output logic [W-1:0] r, output bit e);
    seen = 1'b0;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      r = out_result;
      e = out_err;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic rand_pair(output logic [W-1:0] a, output logic [W-1:0] b);
    int g;
    g = $urandom_range(1, 40);
    a = W'(g * $urandom_range(0, 50));
    b = W'(g * $urandom_range(0, 50));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_err, start, busy} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 10000", {in_ready, out_valid, out_err, start, busy});
    end
    n_cmp++;
    if ({out_result, a_in, b_in} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got res=%0d a=%0d b=%0d want 0", out_result, a_in, b_in);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_core_op();
    bit ok, seen, e;
    logic [W-1:0] r, r0;
    int s0;
    core_lat = 5;
    s0 = start_cnt;
    push_pair(48, 18, ok);
    wait_start(seen);
    n_cmp++;
    if (!seen || a_in !== 48 || b_in !== 18) begin
      n_err++;
      $display("FAIL core_issue: got seen=%0b a=%0d b=%0d want 1/48/18", seen, a_in, b_in);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    r0 = out_result;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!seen || out_valid !== 1'b1 || out_result !== r0) begin
      n_err++;
      $display("FAIL core_hold: got seen=%0b valid=%b res=%0d want 1/1/%0d", seen, out_valid, out_result, r0);
    end
    pop_result(5, seen, r, e);
    n_cmp++;
    if (!seen || r !== 6 || e !== 1'b0) begin
      n_err++;
      $display("FAIL core_result: got seen=%0b res=%0d err=%b want 6/0", seen, r, e);
    end
    n_cmp++;
    if (start_cnt - s0 !== 1 || a_in !== 48) begin
      n_err++;
      $display("FAIL core_start_cnt: got starts=%0d a_in=%0d want 1/48", start_cnt - s0, a_in);
    end
  endtask

  task automatic test_bypass();
    bit ok, seen, e;
    logic [W-1:0] r, x;
    int s0;
    s0 = start_cnt;
    push_pair(0, 35, ok);
    push_pair(0, 0, ok);
    pop_result(20, seen, r, e);
    n_cmp++;
    if (!seen || r !== 35 || e !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_first: got seen=%0b res=%0d err=%b want 35/0", seen, r, e);
    end
    pop_result(20, seen, r, e);
    n_cmp++;
    if (!seen || r !== 0 || e !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_zero: got seen=%0b res=%0d err=%b want 0/0", seen, r, e);
    end
    for (int i = 0; i < 4; i++) begin
      x = W'($urandom_range(1, 100000));
      if (i % 2 == 0) push_pair(x, 0, ok);
      else            push_pair(0, x, ok);
      pop_result(20, seen, r, e);
      n_cmp++;
      if (!seen || r !== x || e !== 1'b0) begin
        n_err++;
        $display("FAIL bypass_rand: got seen=%0b res=%0d err=%b want %0d/0", seen, r, e, x);
      end
    end
    n_cmp++;
    if (start_cnt !== s0) begin
      n_err++;
      $display("FAIL bypass_no_start: got starts=%0d want 0", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, seen, e, any_ready;
    logic [W-1:0] r, a, b;
    logic [W-1:0] exp_q[$];
    int acc;
    core_lat = 3;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      rand_pair(a, b);
      push_pair(a, b, ok);
      if (ok) begin
        acc++;
        exp_q.push_back(ref_gcd(a, b));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (acc !== DEPTH + 1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_full: got acc=%0d in_ready=%b busy=%b want %0d/0/1", acc, in_ready, busy, DEPTH + 1);
    end
    in_valid = 1'b1;
    in_a = 7;
    in_b = 7;
    any_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) any_ready = 1'b1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (any_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_blocked: got in_ready seen=%b want 0", any_ready);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      pop_result(60, seen, r, e);
      n_cmp++;
      if (!seen || exp_q.size() == 0 || r !== exp_q[0] || e !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_order[%0d]: got seen=%0b res=%0d err=%b want %0d/0", i, seen, r, e,
                 exp_q.size() ? exp_q[0] : '0);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_timeout();
    bit ok, seen, e;
    logic [W-1:0] r;
    int cyc;
    core_hang = 1'b1;
    push_pair(12, 8, ok);
    wait_start(seen);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    n_cmp++;
    if (!seen || cyc !== TIMEOUT + 2) begin
      n_err++;
      $display("FAIL timeout_latency: got seen=%0b cycles=%0d want %0d", seen, cyc, TIMEOUT + 2);
    end
    pop_result(5, seen, r, e);
    n_cmp++;
    if (!seen || r !== 0 || e !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_result: got seen=%0b res=%0d err=%b want 0/1", seen, r, e);
    end
    core_hang = 1'b0;
    push_pair(21, 14, ok);
    pop_result(40, seen, r, e);
    n_cmp++;
    if (!seen || r !== 7 || e !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_recover: got seen=%0b res=%0d err=%b want 7/0", seen, r, e);
    end
  endtask

  task automatic test_stale_done();
    bit ok, seen, e;
    logic [W-1:0] r;
    core_lat = 4;
    stale_en = 1'b1;
    push_pair(27, 45, ok);
    wait_start(seen);
    @(posedge clk);
    @(posedge clk);
    #1 stale_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!seen || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stale_early: got seen=%0b out_valid=%b want 1/0", seen, out_valid);
    end
    pop_result(40, seen, r, e);
    n_cmp++;
    if (!seen || r !== 9 || e !== 1'b0) begin
      n_err++;
      $display("FAIL stale_result: got seen=%0b res=%0d err=%b want 9/0", seen, r, e);
    end
  endtask

  task automatic test_random();
    bit ok, seen, e;
    logic [W-1:0] r, a, b;
    for (int i = 0; i < 12; i++) begin
      core_lat = $urandom_range(1, 6);
      rand_pair(a, b);
      push_pair(a, b, ok);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pop_result(60, seen, r, e);
      n_cmp++;
      if (!ok || !seen || r !== ref_gcd(a, b) || e !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d] gcd(%0d,%0d): got seen=%0b res=%0d err=%b want %0d/0", i, a, b,
                 seen, r, e, ref_gcd(a, b));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen, any_act;
    int s0;
    core_hang = 1'b1;
    push_pair(10, 4, ok);
    wait_start(seen);
    push_pair(9, 6, ok);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    core_hang = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_err, start, busy} !== 5'b10000 || {out_result, a_in, b_in} !== '0) begin
      n_err++;
      $display("FAIL midreset_state: got flags=%b res=%0d a=%0d b=%0d want 10000/0/0/0",
               {in_ready, out_valid, out_err, start, busy}, out_result, a_in, b_in);
    end
    s0 = start_cnt;
    any_act = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) any_act = 1'b1;
    end
    n_cmp++;
    if (any_act !== 1'b0 || start_cnt !== s0) begin
      n_err++;
      $display("FAIL midreset_empty: got activity=%b starts=%0d want 0/0", any_act, start_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_core_op();
    test_bypass();
    test_back_to_back();
    test_timeout();
    test_stale_done();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
